// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants and the write-back request record.
package rf_pkg;
    localparam int RF_NREG = 32;
    localparam int RF_AW   = 5;
    localparam int RF_XLEN = 32;
    localparam int RF_X0   = 0;

    typedef struct packed {
        logic [RF_AW-1:0]   addr;
        logic [RF_XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Producer/decode/register-file side of the write-back arbiter.
// RF_WB_FWD_EN adds the forwarding outputs.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = rf_pkg::RF_XLEN,
    parameter int AW   = rf_pkg::RF_AW
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 claim_valid;
    logic [AW-1:0]        claim_addr;
    logic [AW-1:0]        q_addr1, q_addr2;
    logic                 q_busy1, q_busy2;
    logic [AW-1:0]        wadd;
    logic [XLEN-1:0]      wdata;
    logic                 is_wreg;
`ifdef RF_WB_FWD_EN
    logic                 fwd_hit1, fwd_hit2;
    logic [XLEN-1:0]      fwd_data1, fwd_data2;

    modport master (
        output req_valid, req_addr, req_data, claim_valid, claim_addr, q_addr1, q_addr2,
        input  req_ready, q_busy1, q_busy2, wadd, wdata, is_wreg,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
    modport slave (
        input  req_valid, req_addr, req_data, claim_valid, claim_addr, q_addr1, q_addr2,
        output req_ready, q_busy1, q_busy2, wadd, wdata, is_wreg,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
`else
    modport master (
        output req_valid, req_addr, req_data, claim_valid, claim_addr, q_addr1, q_addr2,
        input  req_ready, q_busy1, q_busy2, wadd, wdata, is_wreg
    );
    modport slave (
        input  req_valid, req_addr, req_data, claim_valid, claim_addr, q_addr1, q_addr2,
        output req_ready, q_busy1, q_busy2, wadd, wdata, is_wreg
    );
`endif
endinterface

// File: rtl/rf_wb_arbiter_rr_grant.sv
// Round-robin grant: first valid requester at or after ptr, one-hot plus index.
module rr_grant #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && valid[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter + busy scoreboard for the register file write port.
// Define RF_WB_FWD_EN to forward the in-flight write to the decode queries.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);
    localparam int IW   = $clog2(NREQ);
    localparam int NREG = 1 << AW;

    logic [IW-1:0]   ptr, gidx, ptr_nxt;
    logic [NREQ-1:0] gnt;
    logic            acc;
    logic [AW-1:0]   g_addr;
    logic [XLEN-1:0] g_data;
    logic [NREG-1:0] busy, busy_nxt;
    logic [AW-1:0]   wadd_q;
    logic [XLEN-1:0] wdata_q;
    logic            is_wreg_q;

    rr_grant #(.NREQ(NREQ)) u_grant (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (gidx)
    );

    // grant is only ever raised on a valid line, so any grant is an acceptance
    assign bus.req_ready = gnt;
    assign acc     = |gnt;
    assign g_addr  = bus.req_addr[gidx*AW +: AW];
    assign g_data  = bus.req_data[gidx*XLEN +: XLEN];
    assign ptr_nxt = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;

    // claim is applied after the clear: a younger claim of the same register wins
    always_comb begin
        busy_nxt = busy;
        if (acc) busy_nxt[g_addr] = 1'b0;
        if (bus.claim_valid) busy_nxt[bus.claim_addr] = 1'b1;
        busy_nxt[RF_X0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            wadd_q    <= '0;
            wdata_q   <= '0;
            is_wreg_q <= 1'b0;
            busy      <= '0;
        end else begin
            busy      <= busy_nxt;
            is_wreg_q <= acc && (g_addr != AW'(RF_X0));
            if (acc) begin
                wadd_q  <= g_addr;
                wdata_q <= g_data;
                ptr     <= ptr_nxt;
            end
        end
    end

    assign bus.wadd    = wadd_q;
    assign bus.wdata   = wdata_q;
    assign bus.is_wreg = is_wreg_q;

`ifdef RF_WB_FWD_EN
    assign bus.fwd_hit1  = is_wreg_q && (wadd_q == bus.q_addr1);
    assign bus.fwd_hit2  = is_wreg_q && (wadd_q == bus.q_addr2);
    assign bus.fwd_data1 = wdata_q;
    assign bus.fwd_data2 = wdata_q;
    assign bus.q_busy1   = busy[bus.q_addr1] && !bus.fwd_hit1;
    assign bus.q_busy2   = busy[bus.q_addr2] && !bus.fwd_hit2;
`else
    assign bus.q_busy1   = busy[bus.q_addr1];
    assign bus.q_busy2   = busy[bus.q_addr2];
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset/forwarding sequences,
// and random traffic checked against a spec-level model.
module tb_rf_wb_arbiter;
    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) ifc ();
    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int nchecks = 0;
    int nerrors = 0;

    // reference state: what the write port and scoreboard should hold
    int              m_ptr;
    bit [31:0]       m_busy;
    bit              m_iswreg;
    logic [AW-1:0]   m_wadd;
    logic [XLEN-1:0] m_wdata;

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0, a1;
        logic [31:0] d0;
        logic        cv;
        logic [4:0]  ca, q1;
        logic [1:0]  e_rdy;
        logic        e_qb1, e_wr;
        logic [4:0]  e_wadd;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_iswreg = 0; m_wadd = '0; m_wdata = '0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++)
            if (ifc.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic set_in(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1, input logic cv,
                          input logic [4:0] ca, input logic [4:0] q1, input logic [4:0] q2);
        ifc.req_valid = v;
        ifc.req_addr[0 +: AW] = a0;  ifc.req_addr[AW +: AW] = a1;
        ifc.req_data[0 +: XLEN] = d0; ifc.req_data[XLEN +: XLEN] = d1;
        ifc.claim_valid = cv; ifc.claim_addr = ca;
        ifc.q_addr1 = q1; ifc.q_addr2 = q2;
    endtask

    // clock edge plus model update from the inputs presented during the cycle
    task automatic advance();
        int g;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            cv;
        logic [AW-1:0]   ca;
        g  = model_grant();
        a  = (g >= 0) ? ifc.req_addr[g*AW +: AW] : '0;
        d  = (g >= 0) ? ifc.req_data[g*XLEN +: XLEN] : '0;
        cv = ifc.claim_valid; ca = ifc.claim_addr;
        @(posedge clk);
        if (g >= 0) begin
            m_wadd = a; m_wdata = d; m_iswreg = (a != 0);
            m_ptr = (g + 1) % NREQ;
            m_busy[a] = 1'b0;
        end else m_iswreg = 1'b0;
        if (cv && ca != 0) m_busy[ca] = 1'b1;
        #1;
    endtask

    task automatic check_model();
        int g;
        bit h1, h2;
        g = model_grant();
        h1 = 0; h2 = 0;
`ifdef RF_WB_FWD_EN
        h1 = m_iswreg && (m_wadd == ifc.q_addr1);
        h2 = m_iswreg && (m_wadd == ifc.q_addr2);
        chk("rnd_fwd_hit1", ifc.fwd_hit1, h1);
        chk("rnd_fwd_hit2", ifc.fwd_hit2, h2);
        if (h1) chk("rnd_fwd_data1", ifc.fwd_data1, m_wdata);
`endif
        chk("rnd_ready",   ifc.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("rnd_is_wreg", ifc.is_wreg, m_iswreg);
        chk("rnd_wadd",    ifc.wadd, m_wadd);
        chk("rnd_wdata",   ifc.wdata, m_wdata);
        chk("rnd_q_busy1", ifc.q_busy1, m_busy[ifc.q_addr1] && !h1);
        chk("rnd_q_busy2", ifc.q_busy2, m_busy[ifc.q_addr2] && !h2);
    endtask

    initial begin
        logic exp_qb1;
        int   g;
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // v, a0, a1, d0, cv, ca, q1 | rdy, qb1, wr, wadd
        tv[0]  = '{2'b00, 5'd0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0};
        tv[1]  = '{2'b11, 5'd3, 5'd4, 32'h11,       1'b1, 5'd7, 5'd7, 2'b01, 1'b0, 1'b0, 5'd0};
        tv[2]  = '{2'b11, 5'd3, 5'd4, 32'h11,       1'b0, 5'd0, 5'd7, 2'b10, 1'b1, 1'b1, 5'd3};
        tv[3]  = '{2'b11, 5'd3, 5'd4, 32'h11,       1'b0, 5'd0, 5'd7, 2'b01, 1'b1, 1'b1, 5'd4};
        tv[4]  = '{2'b11, 5'd3, 5'd4, 32'h11,       1'b0, 5'd0, 5'd7, 2'b10, 1'b1, 1'b1, 5'd3};
        tv[5]  = '{2'b00, 5'd3, 5'd4, 32'h11,       1'b0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b1, 5'd4};
        tv[6]  = '{2'b01, 5'd0, 5'd4, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 2'b01, 1'b1, 1'b0, 5'd4};
        tv[7]  = '{2'b00, 5'd0, 5'd4, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b0, 5'd0};
        tv[8]  = '{2'b01, 5'd7, 5'd4, 32'h22,       1'b1, 5'd7, 5'd7, 2'b01, 1'b1, 1'b0, 5'd0};
        tv[9]  = '{2'b00, 5'd7, 5'd7, 32'h22,       1'b0, 5'd0, 5'd7, 2'b00, 1'b1, 1'b1, 5'd7};
        tv[10] = '{2'b10, 5'd7, 5'd7, 32'h22,       1'b0, 5'd0, 5'd7, 2'b10, 1'b1, 1'b0, 5'd7};
        tv[11] = '{2'b00, 5'd7, 5'd7, 32'h22,       1'b0, 5'd0, 5'd7, 2'b00, 1'b0, 1'b1, 5'd7};

        for (int i = 0; i < 12; i++) begin
            set_in(tv[i].v, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d0 + 32'd1,
                   tv[i].cv, tv[i].ca, tv[i].q1, 5'd3);
            #4;
            exp_qb1 = tv[i].e_qb1;
`ifdef RF_WB_FWD_EN
            if (tv[i].e_wr && tv[i].e_wadd == tv[i].q1) exp_qb1 = 1'b0;
`endif
            chk($sformatf("tv%0d_ready", i),   ifc.req_ready, tv[i].e_rdy);
            chk($sformatf("tv%0d_q_busy1", i), ifc.q_busy1, exp_qb1);
            chk($sformatf("tv%0d_q_busy2", i), ifc.q_busy2, 1'b0);
            chk($sformatf("tv%0d_is_wreg", i), ifc.is_wreg, tv[i].e_wr);
            chk($sformatf("tv%0d_wadd", i),    ifc.wadd, tv[i].e_wadd);
            advance();
        end

        // asynchronous reset with a busy register and a live write
        set_in(2'b01, 5'd9, 5'd0, 32'h55, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
        #4;
        advance();
        set_in(2'b11, 5'd3, 5'd4, 32'h1, 32'h2, 1'b0, 5'd0, 5'd5, 5'd0);
        #1;
        chk("pre_rst_q_busy1", ifc.q_busy1, 1'b1);
        chk("pre_rst_is_wreg", ifc.is_wreg, 1'b1);
        chk("pre_rst_ready",   ifc.req_ready, 2'b10);
        rst = 1'b1;
        #1;
        chk("rst_is_wreg", ifc.is_wreg, 1'b0);
        chk("rst_wadd",    ifc.wadd, 5'd0);
        chk("rst_wdata",   ifc.wdata, 32'd0);
        chk("rst_q_busy1", ifc.q_busy1, 1'b0);
        chk("rst_ptr",     ifc.req_ready, 2'b01);
        model_reset();
        #1 rst = 1'b0;
        advance();

`ifdef RF_WB_FWD_EN
        set_in(2'b01, 5'd9, 5'd0, 32'h12345678, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9);
        #4;
        advance();
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        #4;
        chk("fwd_hit2",  ifc.fwd_hit2, 1'b1);
        chk("fwd_data2", ifc.fwd_data2, 32'h12345678);
        chk("fwd_qb2",   ifc.q_busy2, 1'b0);
        advance();
`endif

        // random traffic; a requester holds its request until accepted
        for (int i = 0; i < NREQ; i++) begin
            ifc.req_valid[i] = ($urandom_range(0, 3) != 0);
            ifc.req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            ifc.req_data[i*XLEN +: XLEN] = $urandom;
        end
        for (int c = 0; c < 400; c++) begin
            ifc.claim_valid = ($urandom_range(0, 2) == 0);
            ifc.claim_addr  = AW'($urandom_range(0, 7));
            ifc.q_addr1     = AW'($urandom_range(0, 7));
            ifc.q_addr2     = AW'($urandom_range(0, 7));
            #4;
            check_model();
            g = model_grant();
            advance();
            for (int i = 0; i < NREQ; i++) begin
                if (!ifc.req_valid[i] || i == g) begin
                    ifc.req_valid[i] = ($urandom_range(0, 3) != 0);
                    ifc.req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    ifc.req_data[i*XLEN +: XLEN] = $urandom;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It lets several result producers (ALU, load unit, multi-cycle mul/div) share the single register-file write port through a round-robin grant with valid/ready handshakes. It registers the winning request onto the write port and tracks which destination registers still have a result outstanding, so decode can stall on hazards. It sits between the execute-side producers and the register file's write inputs.

## Interface
Parameters:
- NREQ, 2, number of write-back requesters (2..4)
- XLEN, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a result to write
- req_ready  out  NREQ  requester i is accepted this cycle
- req_addr  in  NREQ*AW  destination for requester i, slice [i*AW +: AW]
- req_data  in  NREQ*XLEN  result for requester i, slice [i*XLEN +: XLEN]
- claim_valid  in  1  decode issues an instruction that will write claim_addr
- claim_addr  in  AW  destination being claimed
- q_addr1, q_addr2  in  AW each  source registers queried by decode
- q_busy1, q_busy2  out  1 each  queried register has an outstanding result
- wadd  out  AW  register-file write address
- wdata  out  XLEN  register-file write data
- is_wreg  out  1  register-file write enable

## Operation
- Grant is combinational and round-robin. Search starts at pointer `ptr` and takes the first i with req_valid[i]=1. Exactly that bit of req_ready is 1; all others are 0. If no requester is valid, req_ready is all 0.
- Acceptance: req_valid[i] & req_ready[i]. On the next edge:
  - wadd ← req_addr[i], wdata ← req_data[i]
  - is_wreg ← (req_addr[i] != 0)
  - ptr ← (i+1) mod NREQ
- No acceptance: is_wreg ← 0. wadd and wdata hold. ptr holds.
- Writes to x0 are accepted and handshaken but never assert is_wreg.
- Scoreboard `busy[31:0]`:
  - Claim with claim_addr≠0 sets busy[claim_addr].
  - Acceptance clears busy[req_addr[i]].
  - Same address set and cleared in one cycle: set wins, because the claim belongs to a younger instruction.
  - busy[0] is constant 0.
- q_busyN = busy[q_addrN], combinational. The queried result reflects state before the current edge.
- A requester must hold valid, addr and data stable until it sees ready. The arbiter never drops an accepted request.

## Timing
- Reset values: is_wreg=0, wadd=0, wdata=0, ptr=0, busy=all 0. req_ready is all 0 while no requester is valid.
- Reset asserted mid-operation clears all state immediately. A request pending at that time is lost, and the requester must re-present it.
- Latency: acceptance at edge n means is_wreg/wadd/wdata are valid during cycle n+1, and the register file commits at edge n+1.
- Throughput: one write per cycle, sustained.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- ptr wrap: from NREQ-1 it returns to 0.
- Claim at edge n gives q_busy=1 from cycle n+1. Acceptance at edge m gives q_busy=0 from cycle m+1.

## Configuration
- RF_WB_FWD_EN defined:
  - Adds outputs fwd_hit1, fwd_hit2 (1 bit each) and fwd_data1, fwd_data2 (XLEN each).
  - fwd_hitN = is_wreg & (wadd == q_addrN); fwd_dataN = wdata.
  - When fwd_hitN=1, q_busyN is forced to 0, so decode takes the in-flight value instead of stalling.
- RF_WB_FWD_EN undefined: those ports do not exist, and q_busyN is the raw scoreboard bit.

## Structure
- Shared package `rf_pkg`: constants for register count (32), AW, XLEN, the x0 index, and a `wb_req_t` typedef holding addr and data.
- One sub-module, `rr_grant`. It is parameterized by NREQ, takes the valid vector and ptr, and returns a one-hot grant plus the granted index.
- The top level holds ptr, the output registers, the scoreboard, and the optional forwarding logic.

## Test plan
- Reset then idle → is_wreg=0, wadd=0, wdata=0, req_ready=00, q_busy1=q_busy2=0.
- NREQ=2, both valid for 4 cycles, addrs 3/4 → grants alternate 0,1,0,1. is_wreg=1 every cycle one cycle later, with wadd sequence 3,4,3,4.
- Requester 0 writes x0 with data 0xDEADBEEF → req_ready[0]=1, and is_wreg stays 0 the next cycle.
- Claim x7 at edge n → q_busy1=1 for q_addr1=7 from cycle n+1. Accept write to x7 with a simultaneous claim of x7 → busy stays 1. Accept a later write to x7 → q_busy1=0.
- Assert rst while busy[5]=1 and is_wreg=1 → busy, is_wreg and ptr clear within the same cycle, with no clock edge needed.
- With RF_WB_FWD_EN, accept write x9=0x12345678 and query q_addr2=9 next cycle → fwd_hit2=1, fwd_data2=0x12345678, q_busy2=0.
